// File: rtl/audio_dac_stream.sv
`timescale 1ns/1ps
// audio_dac_stream: buffered stereo sample sinks serialised onto codec DACDAT (I2S or left-justified).
// Optional: define AUDIO_DAC_UNDERRUN_CNT_EN to add a saturating underrun counter with a clear input.
module audio_dac_stream #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MODE       = 0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] left_sink_data,
  input  logic              left_sink_valid,
  output logic              left_sink_ready,
  input  logic [DATA_W-1:0] right_sink_data,
  input  logic              right_sink_valid,
  output logic              right_sink_ready,
  input  logic              bclk,
  input  logic              daclrck,
  output logic              dacdat,
  output logic              underrun
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
  ,
  input  logic              clear_count,
  output logic [15:0]       underrun_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic LEFT_LVL = (MODE == 1);

  typedef enum logic [1:0] {IDLE, WAIT1, SHIFT, PAD} state_t;

  logic              rst_done;
  logic [1:0]        bclk_sync, lrck_sync;
  logic              bclk_prev, lrck_prev, bf, lre;
  logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_l, rd_l, wr_r, rd_r;
  logic [CW-1:0]     cnt_l, cnt_r;
  logic              push_l, push_r, pop, left_start, empty_l, empty_r;
  logic [DATA_W-1:0] pair_l, pair_r, word, hold_r, shreg;
  logic [BW-1:0]     bitcnt;
  state_t            state;

  // Codec clocks are async: two-flop synchronise, then register one-cycle edge strobes.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rst_done  <= 1'b0;
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
      bf        <= 1'b0;
      lre       <= 1'b0;
    end else begin
      rst_done  <= 1'b1;
      bclk_sync <= {bclk_sync[0], bclk};
      lrck_sync <= {lrck_sync[0], daclrck};
      bclk_prev <= bclk_sync[1];
      lrck_prev <= lrck_sync[1];
      bf        <= bclk_prev & ~bclk_sync[1];
      lre       <= lrck_prev ^ lrck_sync[1];
    end
  end

  assign left_start       = lre && (lrck_prev == LEFT_LVL);
  assign empty_l          = (cnt_l == '0);
  assign empty_r          = (cnt_r == '0);
  assign left_sink_ready  = rst_done && (cnt_l != CW'(FIFO_DEPTH));
  assign right_sink_ready = rst_done && (cnt_r != CW'(FIFO_DEPTH));
  assign push_l           = left_sink_valid && left_sink_ready;
  assign push_r           = right_sink_valid && right_sink_ready;
  assign pop              = left_start && enable && !empty_l && !empty_r;
  assign pair_l           = pop ? mem_l[rd_l] : '0;
  assign pair_r           = pop ? mem_r[rd_r] : '0;
  assign word             = left_start ? pair_l : hold_r;

  always_ff @(posedge clk_clk) begin
    if (push_l) mem_l[wr_l] <= left_sink_data;
    if (push_r) mem_r[wr_r] <= right_sink_data;
  end

  // Pairs leave only together, so a lone sample in one FIFO waits for its partner.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_l  <= '0;
      rd_l  <= '0;
      cnt_l <= '0;
      wr_r  <= '0;
      rd_r  <= '0;
      cnt_r <= '0;
    end else begin
      if (push_l) wr_l <= wr_l + 1'b1;
      if (push_r) wr_r <= wr_r + 1'b1;
      if (pop) begin
        rd_l <= rd_l + 1'b1;
        rd_r <= rd_r + 1'b1;
      end
      if (push_l && !pop)      cnt_l <= cnt_l + 1'b1;
      else if (pop && !push_l) cnt_l <= cnt_l - 1'b1;
      if (push_r && !pop)      cnt_r <= cnt_r + 1'b1;
      else if (pop && !push_r) cnt_r <= cnt_r - 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      underrun <= 1'b0;
    end else begin
      underrun <= left_start && enable && (empty_l || empty_r);
    end
  end

  // Any LRCK edge restarts the word, so a short half-frame simply truncates it.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state  <= IDLE;
      hold_r <= '0;
      shreg  <= '0;
      bitcnt <= '0;
      dacdat <= 1'b0;
    end else begin
      if (left_start) hold_r <= pair_r;
      if (lre) begin
        if (MODE == 1) begin
          dacdat <= word[DATA_W-1];
          shreg  <= {word[DATA_W-2:0], 1'b0};
          bitcnt <= BW'(DATA_W - 1);
          state  <= SHIFT;
        end else begin
          shreg  <= word;
          bitcnt <= BW'(DATA_W);
          state  <= WAIT1;
        end
      end else if (bf) begin
        case (state)
          WAIT1, SHIFT: begin
            if (bitcnt == '0) begin
              dacdat <= 1'b0;
              state  <= PAD;
            end else begin
              dacdat <= shreg[DATA_W-1];
              shreg  <= {shreg[DATA_W-2:0], 1'b0};
              bitcnt <= bitcnt - 1'b1;
              state  <= SHIFT;
            end
          end
          PAD:     dacdat <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      underrun_count <= '0;
    end else if (clear_count) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_dac_stream.sv
`timescale 1ns/1ps
// tb_audio_dac_stream: directed bench driving a codec clock model into an I2S and a left-justified instance.
module tb_audio_dac_stream;

  localparam int DW = 16;
  localparam int HB = 20;

  typedef struct {
    logic        push;
    logic        en;
    logic [15:0] l;
    logic [15:0] r;
    logic [39:0] exp_bits;
    int          exp_under;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, bclk = 1'b1, daclrck = 1'b1;
  logic en0 = 1'b0, en1 = 1'b0;
  logic [DW-1:0] ld0 = '0, rd0 = '0, ld1 = '0, rd1 = '0;
  logic lv0 = 1'b0, rv0 = 1'b0, lv1 = 1'b0, rv1 = 1'b0;
  logic lr0, rr0, dd0, un0, lr1, rr1, dd1, un1;
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
  logic clr0 = 1'b0, clr1 = 1'b0;
  logic [15:0] ucnt0, ucnt1;
`endif

  int errors = 0, checks = 0;
  int under0 = 0, acc_l0 = 0, acc_r0 = 0;
  logic [2*HB-1:0] cap0, cap1;
  vec_t vecs [7];

  audio_dac_stream #(.DATA_W(DW), .FIFO_DEPTH(8), .MODE(0)) dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(en0),
    .left_sink_data(ld0), .left_sink_valid(lv0), .left_sink_ready(lr0),
    .right_sink_data(rd0), .right_sink_valid(rv0), .right_sink_ready(rr0),
    .bclk(bclk), .daclrck(daclrck), .dacdat(dd0), .underrun(un0)
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    , .clear_count(clr0), .underrun_count(ucnt0)
`endif
  );

  audio_dac_stream #(.DATA_W(DW), .FIFO_DEPTH(8), .MODE(1)) dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(en1),
    .left_sink_data(ld1), .left_sink_valid(lv1), .left_sink_ready(lr1),
    .right_sink_data(rd1), .right_sink_valid(rv1), .right_sink_ready(rr1),
    .bclk(bclk), .daclrck(daclrck), .dacdat(dd1), .underrun(un1)
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    , .clear_count(clr1), .underrun_count(ucnt1)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change just after rising edges, so the falling edge sees settled handshakes.
  always @(negedge clk) begin
    if (un0) under0++;
    if (lv0 && lr0) acc_l0++;
    if (rv0 && rr0) acc_r0++;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One codec frame: LRCK low half then high half, BCLK 160 ns, DACDAT sampled on BCLK rise.
  task automatic run_frame();
    @(negedge clk);
    for (int h = 0; h < 2; h++) begin
      for (int b = 0; b < HB; b++) begin
        bclk = 1'b0;
        if (b == 0) daclrck = logic'(h);
        #80;
        bclk = 1'b1;
        cap0[2*HB-1-(h*HB+b)] = dd0;
        cap1[2*HB-1-(h*HB+b)] = dd1;
        #80;
      end
    end
  endtask

  task automatic apply_stimulus(input logic dol, input logic dor, input logic [15:0] l, input logic [15:0] r);
    @(posedge clk); #1;
    ld0 = l; rd0 = r; lv0 = dol; rv0 = dor;
    @(posedge clk); #1;
    lv0 = 1'b0; rv0 = 1'b0;
  endtask

  initial begin
    int u, a_l, a_r;
    logic [2*HB-1:0] cap_or;
    logic [15:0] kl, kr;

    vecs[0] = '{1'b1, 1'b1, 16'hA5C3, 16'h0F0F, 40'h52E1807878, 0};
    vecs[1] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, {1'b0, 16'hFFFF, 4'h0, 16'h0001, 3'b0}, 0};
    vecs[2] = '{1'b1, 1'b1, 16'h8000, 16'h7FFE, {1'b0, 16'h8000, 4'h0, 16'h7FFE, 3'b0}, 0};
    vecs[3] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 40'h0, 1};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 40'h0, 0};
    vecs[5] = '{1'b1, 1'b0, 16'h1234, 16'h5678, 40'h0, 0};
    vecs[6] = '{1'b0, 1'b1, 16'h0000, 16'h0000, {1'b0, 16'h1234, 4'h0, 16'h5678, 3'b0}, 0};

    repeat (3) @(negedge clk);
    check_output("reset_left_ready", lr0, 0);
    check_output("reset_right_ready", rr0, 0);
    check_output("reset_dacdat", dd0, 0);
    check_output("reset_underrun", un0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("post_reset_left_ready", lr0, 1);
    check_output("post_reset_right_ready", rr0, 1);
    check_output("post_reset_dacdat", dd0, 0);
    check_output("post_reset_lj_ready", lr1, 1);
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    check_output("post_reset_count", ucnt0, 0);
`endif

    en0 = 1'b1;
    u = under0;
    cap_or = '0;
    repeat (4) begin
      run_frame();
      cap_or = cap_or | cap0;
    end
    check_output("empty_frames_underruns", under0 - u, 4);
    check_output("empty_frames_dacdat", cap_or, 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].push) apply_stimulus(1'b1, 1'b1, vecs[i].l, vecs[i].r);
      en0 = vecs[i].en;
      u = under0;
      run_frame();
      check_output($sformatf("vec%0d_bits", i), cap0, vecs[i].exp_bits);
      check_output($sformatf("vec%0d_underrun", i), under0 - u, vecs[i].exp_under);
    end

    // Left-justified instance: left half is LRCK high, MSB on the LRCK edge itself.
    en0 = 1'b0;
    @(posedge clk); #1;
    ld1 = 16'hA5C3; rd1 = 16'h0F0F; lv1 = 1'b1; rv1 = 1'b1;
    @(posedge clk); #1;
    lv1 = 1'b0; rv1 = 1'b0;
    en1 = 1'b1;
    run_frame();
    check_output("lj_left_half", cap1[19:0], {16'hA5C3, 4'h0});
    run_frame();
    check_output("lj_right_half", cap1[39:20], {16'h0F0F, 4'h0});
    en1 = 1'b0;

    en0 = 1'b1;
    for (int k = 1; k <= 8; k++) apply_stimulus(1'b1, 1'b1, 16'h1000 + 16'(k), 16'h2000 + 16'(k));
    @(negedge clk);
    check_output("full_left_ready", lr0, 0);
    check_output("full_right_ready", rr0, 0);
    @(posedge clk); #1;
    ld0 = 16'h1009; rd0 = 16'h2009; lv0 = 1'b1; rv0 = 1'b1;
    a_l = acc_l0;
    a_r = acc_r0;
    repeat (4) @(negedge clk);
    check_output("full_ninth_held", acc_l0 - a_l, 0);
    run_frame();
    @(posedge clk); #1;
    lv0 = 1'b0; rv0 = 1'b0;
    @(negedge clk);
    check_output("ninth_left_accepted", acc_l0 - a_l, 1);
    check_output("ninth_right_accepted", acc_r0 - a_r, 1);
    check_output("refull_left_ready", lr0, 0);
    check_output("full_first_pair", cap0, {1'b0, 16'h1001, 4'h0, 16'h2001, 3'b0});
    for (int k = 2; k <= 9; k++) begin
      kl = 16'h1000 + 16'(k);
      kr = 16'h2000 + 16'(k);
      run_frame();
      check_output($sformatf("drain_pair%0d", k), cap0, {1'b0, kl, 4'h0, kr, 3'b0});
    end

    for (int k = 1; k <= 3; k++) apply_stimulus(1'b1, 1'b0, 16'h3000 + 16'(k), 16'h0);
    u = under0;
    run_frame();
    check_output("lone_left_underrun", under0 - u, 1);
    check_output("lone_left_silence", cap0, 0);
    for (int k = 1; k <= 3; k++) begin
      kl = 16'h3000 + 16'(k);
      kr = 16'h4000 + 16'(k);
      apply_stimulus(1'b0, 1'b1, 16'h0, kr);
      u = under0;
      run_frame();
      check_output($sformatf("late_pair%0d", k), cap0, {1'b0, kl, 4'h0, kr, 3'b0});
      check_output($sformatf("late_pair%0d_underrun", k), under0 - u, 0);
    end

`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    @(posedge clk); #1;
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    @(negedge clk);
    check_output("count_cleared", ucnt0, 0);
    repeat (5) run_frame();
    check_output("count_five", ucnt0, 5);
    u = under0;
    fork
      run_frame();
      begin
        for (int n = 0; n < 2000 && !un0; n++) @(negedge clk);
        if (un0) begin
          clr0 = 1'b1;
          @(negedge clk);
          clr0 = 1'b0;
        end
      end
    join
    check_output("count_sixth_underrun_seen", under0 - u, 1);
    check_output("count_clear_wins", ucnt0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_dac_stream.md
Name: audio_dac_stream

Overview:
Parametrised stereo playback engine between Avalon-ST left/right sample sinks and the codec DAC serial pins. Each channel has its own sample FIFO. The block samples the codec-driven BCLK/DACLRCK in the system clock domain and serialises one left/right sample pair per frame onto DACDAT, in I2S or left-justified format. It replaces the fixed 16-bit, unbuffered audio core sink path, and adds configurable width, depth, format, underrun handling and a mute/enable gate.

Parameters:
DATA_W, 16, sample width in bits (8..32); MSB-first on the wire.
FIFO_DEPTH, 8, entries per channel FIFO; power of two, >= 2.
MODE, 0, 0 = I2S (MSB one BCLK after LRCK edge, left when LRCK=0); 1 = left-justified (MSB on LRCK edge, left when LRCK=1).

Ports:
clk_clk  input  1  system clock; all logic on rising edge
reset_reset_n  input  1  asynchronous active-low reset
enable  input  1  1 = play; 0 = mute output, no pops
left_sink_data  input  DATA_W  left sample
left_sink_valid  input  1  left sample valid
left_sink_ready  output  1  left FIFO not full
right_sink_data  input  DATA_W  right sample
right_sink_valid  input  1  right sample valid
right_sink_ready  output  1  right FIFO not full
bclk  input  1  codec bit clock, asynchronous to clk_clk
daclrck  input  1  codec DAC LR clock, asynchronous to clk_clk
dacdat  output  1  serial DAC data, registered
underrun  output  1  one-cycle pulse when a frame starts without a complete pair

Behaviour:
- Reset: all FIFOs empty; dacdat=0; underrun=0; *_ready=0 while reset is asserted, then 1 on the first cycle after release. Synchroniser flops reset to 0.
- Sync: bclk and daclrck each pass through 2-FF synchronisers, then an edge-detect register. The bclk falling edge (bf) and any daclrck change (lre) are each one-cycle strobes, 3 clk_clk after the pin edge. clk_clk must be >= 4x bclk.
- FIFO push: on valid && ready, per channel, independently. ready = !full, driven from the registered count.
- FIFO pop: only at a left-frame start, i.e. lre where the new synced LRCK equals the left level for MODE. Both FIFOs pop together only when enable=1 and both are non-empty. The popped pair is latched into hold_l and hold_r.
- Underrun case: enable=1, left-frame start, and either FIFO empty. Then there is no pop, underrun pulses for 1 cycle, and hold_l/hold_r are loaded with 0 (silence) for that frame. A lone sample in the non-empty FIFO stays queued.
- Enable=0: no pops and no underrun pulse; hold registers are loaded with 0. Enable is sampled only at left-frame start; mid-frame changes take effect at the next one.
- Simultaneous push and pop on the same FIFO in one cycle: both happen and the count is unchanged. A push to a full FIFO cannot occur (ready=0).
- Serialiser FSM, states IDLE, WAIT1, SHIFT, PAD:
  - Any lre: load shreg with hold_l (left-frame start, same cycle as the pop) or hold_r (right half) and set bitcnt=DATA_W.
  - MODE=1: go to SHIFT with dacdat=MSB on that same cycle.
  - MODE=0: go to WAIT1. On the next bf, dacdat=MSB and go to SHIFT.
  - SHIFT: each bf shifts out the next bit. After DATA_W bits, go to PAD.
  - PAD: dacdat=0 on the next bf and stays 0 until the next lre.
  - IDLE: entered only from reset; leaves on the first lre.
- Half-frame too short: an lre arriving mid-word aborts the current word and restarts per the lre rules above. No error is flagged.
- Latency: a pair pushed into empty FIFOs is first output at the next left-frame start. The MSB reaches the pin 4 clk_clk after the LRCK pin edge (LJ), or 4 clk_clk after the following BCLK falling edge (I2S).

Optional Feature:
AUDIO_DAC_UNDERRUN_CNT_EN:
- Defined: adds output underrun_count [15:0]. It increments on each underrun pulse, saturates at 0xFFFF, clears on reset, and is cleared by a new input clear_count (1 cycle, synchronous; clear wins over a same-cycle increment).
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset then release, no stimulus -> both ready=1, dacdat=0, underrun=0. Hold for 4 LRCK frames with enable=1 -> 4 underrun pulses, dacdat stays 0.
- MODE=0, DATA_W=16, push L=0xA5C3, R=0x0F0F, enable=1, BCLK=64 clk_clk period -> left half: 1 BCLK delay, then 1010010111000011, then zeros. Right half: 0000111100001111.
- MODE=1 with the same pair and LRCK high = left -> MSB 1 appears on the same half-frame edge with no delay. Bitstream is otherwise identical.
- Push 8 pairs with no LRCK (FIFO_DEPTH=8) -> both ready=0 after the 8th accept. 9th valid held, not accepted. After one left-frame start, ready returns to 1 and the 9th sample is accepted.
- Push 3 left samples, 0 right -> underrun at the next frame start and left count stays 3. Push 1 right -> the next frame pops the pair (L1, R1).
- AUDIO_DAC_UNDERRUN_CNT_EN defined, run 5 empty frames -> underrun_count=5. Pulse clear_count on the same cycle as a 6th underrun -> count=0.
